// File: rtl/pattern_matcher.sv
// pattern_matcher: compares each frame byte against a masked pattern word
// fetched from the pattern memory. It reports one pass/fail result per
// enabled frame, two cycles after the frame's last byte is accepted.
module pattern_matcher (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_frame_data,
  input  logic        s_frame_valid,
  input  logic        s_frame_last,
  output logic [10:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        match_valid,
  output logic        match_result,
  output logic [10:0] match_offset
);

  localparam logic [10:0] IDX_MAX = 11'h7FF;

  typedef enum logic [2:0] {IDLE, CMP, PASS, FAIL, SKIP} state_t;

  // Byte counter; it is also the memory read address of the next expected byte.
  logic [10:0] idx_q, idx_d;

  // Input stage: this byte lines up with mem_data one cycle after acceptance.
  logic        vld_q, last_q, en_q;
  logic [7:0]  data_q;
  logic [10:0] bidx_q;

  // FSM state, the captured fail offset, and the one-deep result stage.
  state_t      state_q;
  logic        res_q;
  logic [10:0] off_q;
  logic        emit_q, eres_q;
  logic [10:0] eoff_q;

  // Output registers.
  logic        match_valid_q, match_result_q;
  logic [10:0] match_offset_q;

  // Compare outcome for the staged byte.
  logic        mism, endm;
  logic [10:0] count;
  state_t      cmp_next;
  logic        cmp_emit, cmp_res;
  logic [10:0] cmp_off;

  // Bits [31:17] of the pattern word carry no meaning here.
  logic unused_hi;
  assign unused_hi = ^mem_data[31:17];

  assign mem_addr = idx_q;

  // Next index: clear at end of frame, otherwise count up and stick at the top.
  always_comb begin
    idx_d = idx_q;
    if (s_frame_valid) begin
      if (s_frame_last)         idx_d = '0;
      else if (idx_q != IDX_MAX) idx_d = idx_q + 11'd1;
    end
  end

  // Byte counter and input stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      en_q   <= 1'b0;
      data_q <= '0;
      bidx_q <= '0;
    end else begin
      idx_q  <= idx_d;
      vld_q  <= s_frame_valid;
      last_q <= s_frame_valid & s_frame_last;
      en_q   <= enable;
      data_q <= s_frame_data;
      bidx_q <= idx_q;
    end
  end

  assign mism  = ((data_q ^ mem_data[7:0]) & mem_data[15:8]) != 8'h00;
  assign endm  = mem_data[16];
  assign count = (bidx_q == IDX_MAX) ? IDX_MAX : bidx_q + 11'd1;

  // Evaluate the staged byte; the mismatch check takes priority over the end marker.
  always_comb begin
    cmp_next = CMP;
    cmp_emit = 1'b0;
    cmp_res  = 1'b0;
    cmp_off  = bidx_q;
    if (mism) begin
      cmp_next = last_q ? IDLE : FAIL;
      cmp_emit = last_q;
    end else if (endm) begin
      cmp_next = last_q ? IDLE : PASS;
      cmp_emit = last_q;
      cmp_res  = 1'b1;
      cmp_off  = '0;
    end else if (last_q) begin
      cmp_next = IDLE;
      cmp_emit = 1'b1;
      cmp_off  = count;
    end else if (bidx_q == IDX_MAX) begin
      cmp_next = FAIL;
    end
  end

  // Frame FSM. It advances only on staged bytes and queues one result per enabled frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= 1'b0;
      off_q   <= '0;
      emit_q  <= 1'b0;
      eres_q  <= 1'b0;
      eoff_q  <= '0;
    end else begin
      emit_q <= 1'b0;
      if (vld_q) begin
        case (state_q)
          IDLE, CMP: begin
            if (state_q == CMP || en_q) begin
              state_q <= cmp_next;
              res_q   <= cmp_res;
              off_q   <= cmp_off;
              if (cmp_emit) begin
                emit_q <= 1'b1;
                eres_q <= cmp_res;
                eoff_q <= cmp_off;
              end
            end else if (!last_q) begin
              state_q <= SKIP;
            end
          end
          PASS, FAIL: begin
            if (last_q) begin
              state_q <= IDLE;
              emit_q  <= 1'b1;
              eres_q  <= res_q;
              eoff_q  <= off_q;
            end
          end
          SKIP:    if (last_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Result outputs; result and offset move only with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_valid_q  <= 1'b0;
      match_result_q <= 1'b0;
      match_offset_q <= '0;
    end else begin
      match_valid_q <= emit_q;
      if (emit_q) begin
        match_result_q <= eres_q;
        match_offset_q <= eoff_q;
      end
    end
  end

  assign match_valid  = match_valid_q;
  assign match_result = match_result_q;
  assign match_offset = match_offset_q;

endmodule

// File: tb/tb_pattern_matcher.sv
// Bench for pattern_matcher. The driver issues frames and pushes the
// frame-level expected result into a scoreboard. A negedge monitor pops an
// entry on each pulse and checks the result, offset and arrival cycle.
module tb_pattern_matcher;

  logic        clk = 1'b0;
  logic        rst, enable, s_frame_valid, s_frame_last;
  logic [7:0]  s_frame_data;
  logic [10:0] mem_addr;
  logic [31:0] mem_data;
  logic        match_valid, match_result;
  logic [10:0] match_offset;

  pattern_matcher dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_frame_data(s_frame_data), .s_frame_valid(s_frame_valid),
    .s_frame_last(s_frame_last), .mem_addr(mem_addr), .mem_data(mem_data),
    .match_valid(match_valid), .match_result(match_result),
    .match_offset(match_offset)
  );

  always #5 clk = ~clk;

  // Pattern memory: one-cycle registered read port.
  logic [31:0] mem [2048];
  always @(posedge clk) mem_data <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef logic [7:0] bq_t[$];
  typedef struct {bit res; logic [10:0] off; int cyc;} exp_t;
  exp_t sb[$];
  bit          hold_res;
  logic [10:0] hold_off;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference: walk the pattern words until a mismatch, an end marker,
  // or the counter limit is reached.
  function automatic void model(input bq_t b, input bit en, output bit emit,
                                output bit res, output logic [10:0] off);
    emit = en; res = 1'b0; off = '0;
    if (!en) return;
    for (int i = 0; i < b.size(); i++) begin
      logic [31:0] w;
      w = mem[i];
      if (((b[i] ^ w[7:0]) & w[15:8]) != 8'h00) begin off = 11'(i); return; end
      if (w[16]) begin res = 1'b1; return; end
      if (i == 2047) begin off = 11'd2047; return; end
    end
    off = (b.size() > 2047) ? 11'd2047 : 11'(b.size());
  endfunction

  task automatic set_pat(input bq_t p, input int endpos);
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    for (int i = 0; i < p.size(); i++)
      mem[i] = {15'd0, (i == endpos), 8'hFF, p[i]};
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t b, input bit en, input int gapmax, input bit tog);
    bit emit, res;
    logic [10:0] off;
    exp_t e;
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(gapmax, 0)) begin
        s_frame_valid = 1'b0;
        enable = 1'($urandom);
        @(posedge clk); #1;
      end
      s_frame_valid = 1'b1;
      s_frame_data  = b[i];
      s_frame_last  = (i == b.size() - 1);
      enable        = (i == 0 || !tog) ? en : 1'($urandom);
      @(posedge clk); #1;
    end
    s_frame_valid = 1'b0;
    s_frame_last  = 1'b0;
    model(b, en, emit, res, off);
    if (emit) begin
      e.res = res; e.off = off; e.cyc = cyc + 2;
      sb.push_back(e);
    end
    chk("addr_after_last", 32'(mem_addr), 32'd0);
  endtask

  // Monitor: every pulse must match the scoreboard head; between pulses the outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_res = 1'b0;
      hold_off = '0;
    end else if (match_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("result", 32'(match_result), 32'(e.res));
        chk("offset", 32'(match_offset), 32'(e.off));
        chk("latency", 32'(cyc), 32'(e.cyc));
        hold_res = e.res;
        hold_off = e.off;
      end
    end else begin
      chk("valid_low", 32'(match_valid), 32'd0);
      chk("hold_result", 32'(match_result), 32'(hold_res));
      chk("hold_offset", 32'(match_offset), 32'(hold_off));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bq_t pat, f;
    int len;
    rst = 1'b1; enable = 1'b0; s_frame_valid = 1'b0; s_frame_last = 1'b0; s_frame_data = '0;
    pat = {8'h01, 8'h02, 8'h03};
    set_pat(pat, 2);
    idle(3);
    rst = 1'b0;
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_valid",  32'(match_valid), 32'd0);
    chk("rst_result", 32'(match_result), 32'd0);
    chk("rst_offset", 32'(match_offset), 32'd0);

    // Directed frames against the 3-byte pattern.
    f = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_frame(f, 1, 0, 0); idle(4);
    f = {8'h01, 8'h07, 8'h03};               send_frame(f, 1, 0, 0); idle(4);
    f = {8'h01, 8'h02, 8'h09};               send_frame(f, 1, 0, 0); idle(4);
    f = {8'h01, 8'h02};                      send_frame(f, 1, 0, 0); idle(4);
    f = {8'h05, 8'h02, 8'h03};               send_frame(f, 1, 0, 0); idle(4);

    // Word 0 with mask 0 and an end marker accepts any frame.
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[0] = 32'h0001_0000;
    for (int k = 0; k < 4; k++) begin
      f = {8'($urandom)};
      if (k == 3) f.push_back(8'($urandom));
      send_frame(f, 1, 1, 0);
    end
    idle(4);

    // Random frames with gaps, enable toggling and corrupted bytes.
    set_pat(pat, 2);
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(6, 1);
      f.delete();
      for (int j = 0; j < len; j++) f.push_back(j < 3 ? pat[j] : 8'($urandom));
      if ($urandom_range(2, 0) == 0) f[$urandom_range(len - 1, 0)] = 8'($urandom);
      send_frame(f, ($urandom_range(4, 0) != 0), 3, 1'($urandom));
    end

    // Three back-to-back frames: pass, fail, pass.
    f = {8'h01, 8'h02, 8'h03};        send_frame(f, 1, 0, 0);
    f = {8'h01, 8'h05, 8'h03};        send_frame(f, 1, 0, 0);
    f = {8'h01, 8'h02, 8'h03, 8'h09}; send_frame(f, 1, 0, 0);
    idle(4);

    // Disabled at byte 0; then enable toggling inside a passing frame.
    f = {8'h01, 8'h02, 8'h03}; send_frame(f, 0, 0, 0);
    f = {8'h01};               send_frame(f, 0, 0, 0);
    f = {8'h01, 8'h02, 8'h03}; send_frame(f, 1, 0, 1);
    idle(4);

    // Reset in the middle of a frame: no pulse, next frame starts at byte 0.
    s_frame_valid = 1'b1; enable = 1'b1; s_frame_last = 1'b0;
    s_frame_data = 8'h01; @(posedge clk); #1;
    s_frame_data = 8'h02; @(posedge clk); #1;
    s_frame_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_addr",   32'(mem_addr), 32'd0);
    chk("midrst_valid",  32'(match_valid), 32'd0);
    chk("midrst_result", 32'(match_result), 32'd0);
    chk("midrst_offset", 32'(match_offset), 32'd0);
    f = {8'h01, 8'h02, 8'h03}; send_frame(f, 1, 0, 0);
    idle(4);

    // No end marker: a short frame reports its length and a long one saturates.
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; send_frame(f, 1, 0, 0);
    f.delete();
    for (int j = 0; j < 2100; j++) f.push_back(8'($urandom));
    send_frame(f, 1, 0, 0);

    for (int k = 0; k < 10 && sb.size() != 0; k++) idle(1);
    chk("pending_pulses", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_matcher.md
# pattern_matcher

Per-frame pattern comparator for the Ethernet frame detector. It walks the 32-bit read port of the pattern memory in step with incoming frame bytes and compares each byte against a masked pattern byte. At the end of every frame it reports a single pass/fail result. It consumes the memory's read side, while the AXI configuration path owns the write side.

## Interface

Parameters:
- None. Memory address width is fixed at 11 bits and read data width at 32 bits.

Ports:
- clk  in  1  single clock, shared with the pattern memory
- rst  in  1  synchronous, active-high reset
- enable  in  1  matching enable; sampled only on byte 0 of a frame
- s_frame_data  in  8  frame byte
- s_frame_valid  in  1  byte strobe; no backpressure, gaps are allowed
- s_frame_last  in  1  marks the final byte of a frame; qualified by s_frame_valid
- mem_addr  out  11  pattern memory read address (the memory's dpra)
- mem_data  in  32  pattern word; valid 1 cycle after mem_addr is sampled (the memory's qdpo)
- match_valid  out  1  one-cycle result pulse
- match_result  out  1  1 = frame matched; valid while match_valid is high
- match_offset  out  11  on fail: index of the first mismatching byte, or the frame length (saturated at 2047) if the frame ended before the pattern end

## Operation

Pattern word n describes frame byte n:
- [7:0] pattern byte
- [15:8] mask; a 1 bit means that bit is compared
- [16] end marker; byte n is the last byte compared
- [31:17] ignored

Byte n matches when ((s_frame_data ^ word[7:0]) & word[15:8]) == 0. A word with mask 0 matches any byte.

Byte counter `idx` (11 bits):
- Drives mem_addr directly (combinationally).
- Holds the index of the next expected byte.
- Increments on each accepted byte and saturates at 2047.
- Clears to 0 on an accepted byte that has s_frame_last set.

Input stage: each accepted byte is registered together with its valid and last flags and the current `idx`. The compare happens one cycle later against mem_data.

States:
- IDLE: waiting for byte 0.
  - Byte 0 with enable=1 → CMP.
  - Byte 0 with enable=0 → SKIP.
  - Byte 0 that is also last, with enable=0 → stays IDLE; no result pulse.
- CMP: the registered byte is compared against mem_data.
  - Mismatch → FAIL, capture offset = idx of that byte.
  - Match with end marker → PASS.
  - Last without end marker (and no mismatch) → emit fail with offset = byte count → IDLE.
  - Byte at idx 2047 without end marker → FAIL, offset 2047.
- PASS / FAIL: remaining bytes are ignored. On last, emit the result → IDLE.
- SKIP: bytes are ignored. On last → IDLE, no result pulse.

Same-byte events:
- Mismatch on the byte carrying the end marker: fail.
- End marker and last on the same byte: pass.
- Mismatch and last on the same byte: fail, offset = that byte's index.

Reset:
- Clears state to IDLE, `idx` to 0, and the input stage.
- The next accepted byte is treated as byte 0.
- A frame in flight is abandoned without a result pulse.

## Timing

- Reset values: mem_addr=0, match_valid=0, match_result=0, match_offset=0.
- Memory read latency is 1 cycle. The memory samples mem_addr on the same edge that accepts the byte, so the word arrives exactly with the registered byte.
- Result latency: if the last byte is accepted at edge t, match_valid is high for the one cycle following edge t+2.
- match_result and match_offset:
  - Change only together with the match_valid pulse.
  - Hold their values afterwards until the next pulse.
- Throughput: one byte per cycle, including back-to-back frames. Byte 0 of the next frame may arrive in the cycle after the last byte. mem_addr is already 0 then, and the pending result pulse is not disturbed.
- enable changes mid-frame have no effect on the current frame.

## Test plan

- Pattern 0x01,0x02,0x03 with mask 0xFF and the end marker on word 2; frame 01 02 03 04 05, gapless → one pulse, result=1, exactly 2 cycles after the last byte is accepted.
- Same pattern; frame 01 07 03 → result=0, offset=1; mismatch on the end-marker byte (01 02 09) → result=0, offset=2.
- Same pattern; 2-byte frame 01 02 → result=0, offset=2. Word 0 with mask 0 and end marker → any 1-byte frame gives result=1.
- Random valid gaps, then three back-to-back frames (pass, fail, pass) → three pulses in order with correct results; mem_addr returns to 0 after each last byte.
- enable=0 at byte 0 → no pulse for that frame. Toggling enable mid-frame → result unaffected.
- rst asserted mid-frame → outputs zero, no pulse; the next bytes 01 02 03 are matched as a new frame → result=1.
- 2100-byte frame with no end marker in memory → result=0, offset=2047; `idx` saturates at 2047 and does not wrap.
